// File: rtl/db_read_addr_gen.sv
// Affine multi-dimensional read-address generator for memory_core double-buffer mode.
// Walks up to DIMS nested loops, addr = starting_addr + sum(idx_i * stride_i), repeated
// iter_cnt times, stalling on rdy_in backpressure.
// Optional feature: define DB_ADDR_GEN_SWITCH_EN to pulse switch_db with every sweep_done.
module db_read_addr_gen #(
   parameter int unsigned DIMS = 6,
   parameter int unsigned AW   = 16,
   parameter int unsigned RW   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_en,
   input  logic                 flush,
   input  logic                 start,
   input  logic [3:0]           dimensionality,
   input  logic [AW-1:0]        starting_addr,
   input  logic [DIMS*AW-1:0]   strides,
   input  logic [DIMS*RW-1:0]   ranges,
   input  logic [RW-1:0]        iter_cnt,
   input  logic                 rdy_in,
   output logic [AW-1:0]        addr_out,
   output logic                 ren_out,
   output logic                 sweep_done,
   output logic                 done,
   output logic                 busy,
   output logic                 switch_db
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;

   // Job configuration captured on start
   logic [3:0]        dims_q;
   logic [AW-1:0]     base_q;
   logic [AW-1:0]     stride_q   [DIMS];
   logic [RW-1:0]     range_m1_q [DIMS];
   logic [AW-1:0]     rewind_q   [DIMS];
   logic [RW-1:0]     iter_q;

   // Loop state
   logic [RW-1:0]     idx_q      [DIMS];
   logic [RW-1:0]     idx_d      [DIMS];
   logic [RW-1:0]     sweep_cnt_q;
   logic [AW-1:0]     addr_q;
   logic              sweep_done_q;
   logic              done_q;

   // Combinational helpers
   logic [3:0]        dims_clamped;
   logic [RW-1:0]     range_m1_in [DIMS];
   logic [AW-1:0]     rewind_in   [DIMS];
   logic [AW-1:0]     delta;
   logic              wrap_all;
   logic              xfer;
   logic              job_last;

   assign xfer     = (state_q == StRun) && rdy_in && clk_en;
   assign job_last = (sweep_cnt_q + RW'(1)) == iter_q;

   // Clamp the requested dimensionality into 1..DIMS
   always_comb begin
      if (dimensionality == 4'd0) begin
         dims_clamped = 4'd1;
      end else if (32'(dimensionality) > DIMS) begin
         dims_clamped = 4'(DIMS);
      end else begin
         dims_clamped = dimensionality;
      end
   end

   // Per-dim range-1 and rewind amount (range-1)*stride, loaded once at start
   always_comb begin
      for (int unsigned i = 0; i < DIMS; i++) begin
         range_m1_in[i] = (ranges[i*RW +: RW] == '0) ? '0 : ranges[i*RW +: RW] - RW'(1);
         rewind_in[i]   = range_m1_in[i][AW-1:0] * strides[i*AW +: AW];
      end
   end

   // Odometer step: bump the lowest non-saturated dim, rewinding every saturated dim below it
   always_comb begin
      logic carry;
      carry = 1'b1;
      delta = '0;
      idx_d = idx_q;
      for (int unsigned i = 0; i < DIMS; i++) begin
         if (i < 32'(dims_q) && carry) begin
            if (idx_q[i] == range_m1_q[i]) begin
               idx_d[i] = '0;
               delta    = delta - rewind_q[i];
            end else begin
               idx_d[i] = idx_q[i] + RW'(1);
               delta    = delta + stride_q[i];
               carry    = 1'b0;
            end
         end
      end
      wrap_all = carry;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides everything and ignores clk_en
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else if (clk_en) begin
         unique case (state_q)
            StIdle: if (start && iter_cnt != '0) state_d = StRun;
            StRun:  if (xfer && wrap_all && job_last) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath: config capture, loop indices, address and completion pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dims_q       <= 4'd1;
         base_q       <= '0;
         iter_q       <= '0;
         sweep_cnt_q  <= '0;
         addr_q       <= '0;
         sweep_done_q <= 1'b0;
         done_q       <= 1'b0;
         for (int unsigned i = 0; i < DIMS; i++) begin
            stride_q[i]   <= '0;
            range_m1_q[i] <= '0;
            rewind_q[i]   <= '0;
            idx_q[i]      <= '0;
         end
      end else if (flush) begin
         sweep_cnt_q  <= '0;
         sweep_done_q <= 1'b0;
         done_q       <= 1'b0;
         for (int unsigned i = 0; i < DIMS; i++) begin
            idx_q[i] <= '0;
         end
      end else if (clk_en) begin
         sweep_done_q <= 1'b0;
         done_q       <= 1'b0;
         if (state_q == StIdle && start) begin
            if (iter_cnt == '0) begin
               done_q <= 1'b1;
            end else begin
               dims_q      <= dims_clamped;
               base_q      <= starting_addr;
               iter_q      <= iter_cnt;
               sweep_cnt_q <= '0;
               addr_q      <= starting_addr;
               for (int unsigned i = 0; i < DIMS; i++) begin
                  stride_q[i]   <= strides[i*AW +: AW];
                  range_m1_q[i] <= range_m1_in[i];
                  rewind_q[i]   <= rewind_in[i];
                  idx_q[i]      <= '0;
               end
            end
         end else if (xfer) begin
            idx_q <= idx_d;
            if (wrap_all) begin
               sweep_done_q <= 1'b1;
               addr_q       <= base_q;
               if (job_last) begin
                  done_q      <= 1'b1;
                  sweep_cnt_q <= '0;
               end else begin
                  sweep_cnt_q <= sweep_cnt_q + RW'(1);
               end
            end else begin
               addr_q <= addr_q + delta;
            end
         end
      end else begin
         // Pulses last exactly one cycle even while frozen
         sweep_done_q <= 1'b0;
         done_q       <= 1'b0;
      end
   end

   // Outputs
   always_comb begin
      busy       = (state_q == StRun);
      ren_out    = (state_q == StRun);
      addr_out   = addr_q;
      sweep_done = sweep_done_q;
      done       = done_q;
`ifdef DB_ADDR_GEN_SWITCH_EN
      switch_db  = sweep_done_q;
`else
      switch_db  = 1'b0;
`endif
   end

endmodule
